// File: rtl/hilo_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_issue_ctrl_pkg
// Description : XALU op codes, op classifiers, issue FSM state and slot types.
// Revision    : 1.0 - initial release
// ============================================================================
package hilo_issue_ctrl_pkg;

    localparam int c_OP_W   = 4;
    localparam int c_DATA_W = 32;

    // XALU op codes (mt* encoding shared with the multiply/divide unit)
    localparam logic [c_OP_W-1:0] c_MT_NONE       = 4'd0;
    localparam logic [c_OP_W-1:0] c_MT_MULTIPLY   = 4'd1;
    localparam logic [c_OP_W-1:0] c_MT_MULTIPLY_U = 4'd2;
    localparam logic [c_OP_W-1:0] c_MT_DIVIDE     = 4'd3;
    localparam logic [c_OP_W-1:0] c_MT_DIVIDE_U   = 4'd4;
    localparam logic [c_OP_W-1:0] c_MT_MADD       = 4'd5;
    localparam logic [c_OP_W-1:0] c_MT_MADD_U     = 4'd6;
    localparam logic [c_OP_W-1:0] c_MT_MSUB       = 4'd7;
    localparam logic [c_OP_W-1:0] c_MT_MSUB_U     = 4'd8;
    localparam logic [c_OP_W-1:0] c_MT_SET_HI     = 4'd9;
    localparam logic [c_OP_W-1:0] c_MT_SET_LO     = 4'd10;

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE   = 2'd0;
    localparam state_t c_ST_LAUNCH = 2'd1;
    localparam state_t c_ST_WAIT   = 2'd2;

    typedef struct packed {
        logic [c_OP_W-1:0]   ctrl;
        logic [c_DATA_W-1:0] a;
        logic [c_DATA_W-1:0] b;
    } slot_t;

    // Single-cycle register writes: XALU updates HI/LO at the start edge.
    function automatic logic is_set_op(input logic [c_OP_W-1:0] ctrl);
        return (ctrl == c_MT_SET_HI) || (ctrl == c_MT_SET_LO);
    endfunction

    // Multi-cycle ops that raise xalu_busy.
    function automatic logic is_long_op(input logic [c_OP_W-1:0] ctrl);
        logic w_long;
        case (ctrl)
            c_MT_MULTIPLY, c_MT_MULTIPLY_U,
            c_MT_DIVIDE,   c_MT_DIVIDE_U,
            c_MT_MADD,     c_MT_MADD_U,
            c_MT_MSUB,     c_MT_MSUB_U:  w_long = 1'b1;
            default:                     w_long = 1'b0;
        endcase
        return w_long;
    endfunction

endpackage : hilo_issue_ctrl_pkg
`default_nettype wire

// File: rtl/hilo_pend_slot.sv
`default_nettype none
// ============================================================================
// Module      : hilo_pend_slot
// Description : One-entry pending op register with load/launch/flush priority.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_pend_slot
    import hilo_issue_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  i_load,
    input  logic  i_launch,
    input  logic  i_flush,
    input  slot_t i_data,
    output logic  o_valid,
    output slot_t o_data
);

    logic  r_valid;
    slot_t r_data;

    // A load may coincide with the launch of the previous occupant; the new
    // op wins. Launch and flush both empty the slot, so a launching op is
    // unaffected by a simultaneous flush (it has already left).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_launch || i_flush) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule : hilo_pend_slot
`default_nettype wire

// File: rtl/hilo_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hilo_issue_ctrl
// Description : EX-to-XALU issue, HI/LO interlock and read mux, stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_issue_ctrl
    import hilo_issue_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [3:0]       op_ctrl,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    input  logic             rd_valid,
    input  logic             rd_hi,
    input  logic             flush,
    output logic             pipe_stall,
    output logic [31:0]      rd_data,
    output logic             xalu_start,
    output logic [3:0]       xalu_ctrl,
    output logic [31:0]      xalu_a,
    output logic [31:0]      xalu_b,
    input  logic             xalu_busy,
    input  logic [31:0]      xalu_hi,
    input  logic [31:0]      xalu_lo,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic  w_slot_v;
    slot_t w_slot;
    slot_t w_op_data;
    logic  w_launch;
    logic  w_op_stall;
    logic  w_rd_stall;
    logic  w_pipe_stall;
    logic  w_op_accept;

    // Launch only from IDLE so MADD/MSUB see the previous op's final HI/LO.
    assign w_launch   = w_slot_v && (r_state == c_ST_IDLE);

    assign w_op_stall = op_valid && w_slot_v && !w_launch;
    assign w_rd_stall = rd_valid && !((r_state == c_ST_IDLE) && !w_slot_v);
    assign w_pipe_stall = !flush && (w_op_stall || w_rd_stall);

    assign w_op_accept = op_valid && !w_pipe_stall && !flush;
    assign w_op_data   = {op_ctrl, op_a, op_b};

    hilo_pend_slot u_slot (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_op_accept),
        .i_launch (w_launch),
        .i_flush  (flush),
        .i_data   (w_op_data),
        .o_valid  (w_slot_v),
        .o_data   (w_slot)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_launch && is_long_op(w_slot.ctrl)) begin
                    w_state_nxt = c_ST_LAUNCH;
                end
            end
            c_ST_LAUNCH: begin
                w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (!xalu_busy) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_pipe_stall && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
        end
    end

    assign pipe_stall   = w_pipe_stall;
    assign rd_data      = rd_hi ? xalu_hi : xalu_lo;
    assign xalu_start   = w_launch;
    assign xalu_ctrl    = w_slot.ctrl;
    assign xalu_a       = w_slot.a;
    assign xalu_b       = w_slot.b;
    assign stall_cycles = r_stall_cnt;

endmodule : hilo_issue_ctrl
`default_nettype wire
